alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational ALU between two requesters (port 0: execute path; port 1: address/branch-compare path).
- Round-robin arbitration with valid/ready request handshakes.
- Drives the ALU's A, B and ALUControl inputs from registered operands, captures Result and the four flags, and returns them through a per-port response handshake.
- Sits between the control/datapath logic and the ALU instance.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU instance.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 request accepted this cycle when high with req0_valid
- req0_a, req0_b  in  WIDTH  port 0 operands
- req0_op  in  3  port 0 ALUControl code
- req1_valid, req1_ready, req1_a, req1_b, req1_op  as port 0, for port 1
- rsp0_valid, rsp1_valid  out  1  response valid for port 0 / port 1
- rsp0_ready, rsp1_ready  in  1  response consumed by port 0 / port 1
- rsp_result  out  WIDTH  registered ALU result (shared by both ports)
- rsp_flags  out  4  registered {Negative, Zero, Carry, OverFlow}
- rsp_err  out  1  unsupported opcode (see Optional Feature); 0 otherwise
- alu_a, alu_b  out  WIDTH  to ALU A, B
- alu_ctrl  out  3  to ALU ALUControl
- alu_result  in  WIDTH  from ALU Result
- alu_carry, alu_zero, alu_negative, alu_overflow  in  1  from ALU flags

Behaviour:
- States: IDLE, EXEC, RESP.
- Reset: state=IDLE, last_grant=1 so port 0 wins first.
  - Reset values: rsp*_valid=0, rsp_result=0, rsp_flags=0, rsp_err=0, alu_a=0, alu_b=0, alu_ctrl=000.
  - Pending work is discarded; reset mid-EXEC or mid-RESP returns to IDLE next cycle with no response.
- IDLE, grant selection:
  - grant = the only valid port, or, if both are valid, the port != last_grant.
  - reqN_ready = (state==IDLE) && req valid on the granted port. Combinational; never high outside IDLE.
- IDLE, on handshake:
  - Latch a, b, op into operand registers and record the owner.
  - last_grant <= owner; next state EXEC.
  - If no request is valid, stay in IDLE.
- EXEC (exactly 1 cycle):
  - alu_a/alu_b/alu_ctrl come from the operand registers, stable the entire cycle.
  - At end of cycle, capture alu_result into rsp_result and the flags into rsp_flags. Next state RESP.
- RESP:
  - rspN_valid=1 only for the owner.
  - Hold rsp_result, rsp_flags and rsp_err stable until rspN_ready=1, then go to IDLE.
  - Requests arriving during EXEC/RESP wait; their valid must be held by the requester.
- Latency and throughput:
  - Handshake in cycle T; rsp valid from T+2. Minimum 3 cycles per operation.
  - A new grant may occur in the cycle after the response handshake.
- Operand registers hold their last values in IDLE, so the ALU inputs do not toggle when no work is pending.
- Opcodes passed as-is: 000 add, 001 sub, 010 and, 011 or, 101 slt. The arbiter never interprets ALU flags.

Optional Feature:
- Macro: ALU_ARB_OPCHECK_EN.
- Defined:
  - Opcodes 100, 110, 111 are rejected at the IDLE handshake: state goes to RESP directly, skipping EXEC.
  - Response carries rsp_result=0, rsp_flags=0, rsp_err=1.
  - The ALU inputs are not updated for rejected requests.
  - Legal opcodes respond with rsp_err=0.
- Not defined: all codes go through EXEC and rsp_err is tied 0.

Test Plan:
- Reset, then port 0 sends a=0x00000001, b=0x00000005, op=000 → req0_ready high in the accept cycle; rsp0_valid 2 cycles later with rsp_result=0x00000006 and Zero=0.
- Port 1 sends a=0x00001111, b=0x00001111, op=001 → rsp1_valid with rsp_result=0, Zero=1; rsp0_valid stays 0.
- Both ports valid every cycle from reset → grants alternate 0,1,0,1. Each response goes to the correct port, with the result matching that port's operands (port 0 op=011, 0x00000110|0x11110000=0x11110110).
- Hold rsp0_ready=0 for 5 cycles in RESP → rsp0_valid, rsp_result and rsp_flags stay stable; no ready is issued to port 1 until rsp0_ready=1.
- Assert rst during EXEC → next cycle state IDLE, all outputs at reset values, no response emitted; the following request completes normally.
- With ALU_ARB_OPCHECK_EN: op=110 → response 1 cycle after the handshake, rsp_err=1, rsp_result=0, alu_ctrl unchanged. Without the macro: same stimulus passes 110 to alu_ctrl and rsp_err=0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response/ALU signal bundle for alu_arbiter
//
// Groups every non-clock, non-reset signal of alu_arbiter.
//   req0_*/req1_*   : request handshakes with operands and ALUControl code
//   rsp0_*/rsp1_*   : per-port response handshakes
//   rsp_result/flags/err : shared registered response payload
//   alu_*           : connection to the shared combinational ALU
// Modports:
//   slave  : the arbiter side
//   master : the requesters plus ALU side
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_op;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [3:0]       rsp_flags;
    logic             rsp_err;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_zero;
    logic             alu_negative;
    logic             alu_overflow;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp0_ready, rsp1_ready,
        input  alu_result, alu_carry, alu_zero, alu_negative, alu_overflow,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_result, rsp_flags, rsp_err,
        output alu_a, alu_b, alu_ctrl
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp0_ready, rsp1_ready,
        output alu_result, alu_carry, alu_zero, alu_negative, alu_overflow,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_result, rsp_flags, rsp_err,
        input  alu_a, alu_b, alu_ctrl
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two ports
//
// Ports:
//   clk : system clock, all state changes on the rising edge
//   rst : synchronous active-high reset
//   bus : alu_arbiter_if.slave (requests, responses, ALU connection)
// Parameters:
//   WIDTH : operand/result width, must match the ALU instance
// Optional feature macro: ALU_ARB_OPCHECK_EN
//   When defined, opcodes 100/110/111 are rejected at the handshake and
//   answered directly with rsp_err=1 and a zero payload; the ALU inputs are
//   left untouched. When undefined every code is executed and rsp_err is 0.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    state_t           next_state;
    logic             last_grant;
    logic             owner;
    logic             grant;
    logic             accept;
    logic             op_legal;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;
    logic [2:0]       opnd_op;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    logic             req0_ready;
    logic             req1_ready;
    logic             rsp0_valid;
    logic             rsp1_valid;

    // Grant: a lone valid port wins; on contention the port not served last wins.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
        sel_a  = grant ? bus.req1_a  : bus.req0_a;
        sel_b  = grant ? bus.req1_b  : bus.req0_b;
        sel_op = grant ? bus.req1_op : bus.req0_op;
        accept = (state == IDLE) && (grant ? bus.req1_valid : bus.req0_valid);
    end

`ifdef ALU_ARB_OPCHECK_EN
    assign op_legal = (sel_op != 3'b100) && (sel_op != 3'b110) && (sel_op != 3'b111);
`else
    assign op_legal = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = accept && !grant;
                req1_ready = accept && grant;
                if (accept) begin
                    // Rejected opcodes have nothing to compute, so skip EXEC.
                    next_state = op_legal ? EXEC : RESP;
                end
            end
            EXEC: begin
                next_state = RESP;
            end
            RESP: begin
                rsp0_valid = !owner;
                rsp1_valid = owner;
                if (owner ? bus.rsp1_ready : bus.rsp0_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand registers only change on an accepted legal request, so the ALU
    // inputs stay quiet while idle and through rejected requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            opnd_a     <= '0;
            opnd_b     <= '0;
            opnd_op    <= 3'b000;
            result_q   <= '0;
            flags_q    <= 4'b0000;
        end else begin
            if (accept) begin
                last_grant <= grant;
                owner      <= grant;
                if (op_legal) begin
                    opnd_a  <= sel_a;
                    opnd_b  <= sel_b;
                    opnd_op <= sel_op;
                end else begin
                    result_q <= '0;
                    flags_q  <= 4'b0000;
                end
            end
            if (state == EXEC) begin
                result_q <= bus.alu_result;
                flags_q  <= {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow};
            end
        end
    end

`ifdef ALU_ARB_OPCHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= !op_legal;
        end
    end

    assign bus.rsp_err = err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req0_ready = req0_ready;
    assign bus.req1_ready = req1_ready;
    assign bus.rsp0_valid = rsp0_valid;
    assign bus.rsp1_valid = rsp1_valid;
    assign bus.rsp_result = result_q;
    assign bus.rsp_flags  = flags_q;
    assign bus.alu_a      = opnd_a;
    assign bus.alu_b      = opnd_b;
    assign bus.alu_ctrl   = opnd_op;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;
    bit   hs0, hs1;

    alu_arbiter_if #(.WIDTH(32)) bus ();

    alu_arbiter #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {N, Z, C, V, result}.
    function automatic logic [35:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [2:0] op);
        logic [32:0] s;
        logic [31:0] r;
        logic        c;
        logic        v;
        s = 33'd0;
        r = 32'd0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'b000: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'b001: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0];
                c = s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b101:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    function automatic bit is_rej(logic [2:0] op);
`ifdef ALU_ARB_OPCHECK_EN
        return (op == 3'b100) || (op == 3'b110) || (op == 3'b111);
`else
        return 1'b0;
`endif
    endfunction

    always_comb begin
        logic [35:0] f;
        f = alu_fn(bus.alu_a, bus.alu_b, bus.alu_ctrl);
        bus.alu_result   = f[31:0];
        bus.alu_negative = f[35];
        bus.alu_zero     = f[34];
        bus.alu_carry    = f[33];
        bus.alu_overflow = f[32];
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Transaction-timeline model: one job in flight, response visible from
    // accept+2 (accept+1 when rejected) until consumed.
    bit          m_init = 1'b0;
    bit          m_busy, m_owner, m_last, m_err;
    int          m_acc, m_lat;
    int          cyc = 0;
    logic [31:0] m_res, m_a, m_b;
    logic [3:0]  m_flags;
    logic [2:0]  m_op;

    always @(negedge clk) begin
        bit          v0, v1, e_grant, e_r0, e_r1, e_rv, own;
        logic [35:0] f;
        logic [31:0] pa, pb;
        logic [2:0]  pop;
        v0 = bus.req0_valid;
        v1 = bus.req1_valid;
        hs0 = bus.req0_ready && v0;
        hs1 = bus.req1_ready && v1;
        e_grant = (v0 && v1) ? !m_last : v1;
        e_r0 = !m_busy && v0 && !e_grant;
        e_r1 = !m_busy && v1 && e_grant;
        e_rv = m_busy && (cyc >= m_acc + m_lat);
        if (m_init) begin
            check("ready0", 64'(bus.req0_ready), 64'(e_r0));
            check("ready1", 64'(bus.req1_ready), 64'(e_r1));
            check("rsp0_valid", 64'(bus.rsp0_valid), 64'(e_rv && !m_owner));
            check("rsp1_valid", 64'(bus.rsp1_valid), 64'(e_rv && m_owner));
            check("alu_a", 64'(bus.alu_a), 64'(m_a));
            check("alu_b", 64'(bus.alu_b), 64'(m_b));
            check("alu_ctrl", 64'(bus.alu_ctrl), 64'(m_op));
            if (e_rv) begin
                check("rsp_result", 64'(bus.rsp_result), 64'(m_res));
                check("rsp_flags", 64'(bus.rsp_flags), 64'(m_flags));
                check("rsp_err", 64'(bus.rsp_err), 64'(m_err));
            end
        end
        if (rst) begin
            m_init = 1'b1;
            m_busy = 1'b0;
            m_last = 1'b1;
            m_a = 32'd0;
            m_b = 32'd0;
            m_op = 3'd0;
        end else if (m_init) begin
            if (e_r0 || e_r1) begin
                own = e_r1;
                pa  = own ? bus.req1_a : bus.req0_a;
                pb  = own ? bus.req1_b : bus.req0_b;
                pop = own ? bus.req1_op : bus.req0_op;
                m_busy = 1'b1;
                m_owner = own;
                m_last = own;
                m_acc = cyc;
                if (is_rej(pop)) begin
                    m_lat = 1;
                    m_res = 32'd0;
                    m_flags = 4'd0;
                    m_err = 1'b1;
                end else begin
                    f = alu_fn(pa, pb, pop);
                    m_lat = 2;
                    m_res = f[31:0];
                    m_flags = f[35:32];
                    m_err = 1'b0;
                    m_a = pa;
                    m_b = pb;
                    m_op = pop;
                end
            end else if (e_rv && (m_owner ? bus.rsp1_ready : bus.rsp0_ready)) begin
                m_busy = 1'b0;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (3) step();
        rst = 1'b0;
    endtask

    // Raise a request, wait for its ready, then drop valid after the edge.
    task automatic send(bit p, logic [31:0] a, logic [31:0] b, logic [2:0] op);
        bit got;
        got = 1'b0;
        if (p) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (p ? bus.req1_ready : bus.req0_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("send_accepted", 64'(got), 64'd1);
        step();
        if (p) bus.req1_valid = 1'b0;
        else   bus.req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(bit p);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (p ? bus.rsp1_valid : bus.rsp0_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("rsp_seen", 64'(got), 64'd1);
    endtask

    function automatic logic [2:0] rand_op();
        logic [2:0] legal [5];
        legal = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
        if ($urandom_range(0, 9) < 8) return legal[$urandom_range(0, 4)];
        return 3'($urandom_range(0, 7));
    endfunction

    initial begin
        int gr [8];
        int ngr;
        logic [31:0] held_res;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        do_reset();

        // Reset state
        @(negedge clk);
        check("reset_rsp0_valid", 64'(bus.rsp0_valid), 64'd0);
        check("reset_result", 64'(bus.rsp_result), 64'd0);
        check("reset_alu_a", 64'(bus.alu_a), 64'd0);
        check("reset_ready0", 64'(bus.req0_ready), 64'd0);
        step();

        // Port 0 add, latency T+2
        send(1'b0, 32'h1, 32'h5, 3'b000);
        @(negedge clk);
        check("t1_no_rsp_in_exec", 64'(bus.rsp0_valid), 64'd0);
        step();
        @(negedge clk);
        check("t1_rsp0_valid", 64'(bus.rsp0_valid), 64'd1);
        check("t1_result", 64'(bus.rsp_result), 64'h6);
        check("t1_zero", 64'(bus.rsp_flags[2]), 64'd0);
        step();

        // Port 1 sub to zero
        send(1'b1, 32'h1111, 32'h1111, 3'b001);
        wait_rsp(1'b1);
        check("t2_result", 64'(bus.rsp_result), 64'h0);
        check("t2_zero", 64'(bus.rsp_flags[2]), 64'd1);
        check("t2_rsp0_quiet", 64'(bus.rsp0_valid), 64'd0);
        step();

        // Both ports valid continuously from reset
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_a = 32'h110; bus.req0_b = 32'h11110000; bus.req0_op = 3'b011;
        bus.req1_valid = 1'b1; bus.req1_a = 32'h10;  bus.req1_b = 32'h20;       bus.req1_op = 3'b000;
        ngr = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.req0_ready && ngr < 8) begin gr[ngr] = 0; ngr++; end
            if (bus.req1_ready && ngr < 8) begin gr[ngr] = 1; ngr++; end
            if (bus.rsp0_valid) check("t3_rsp0_result", 64'(bus.rsp_result), 64'h11110110);
            if (bus.rsp1_valid) check("t3_rsp1_result", 64'(bus.rsp_result), 64'h30);
            step();
        end
        check("t3_grant_count", 64'(ngr >= 4), 64'd1);
        if (ngr >= 4) begin
            check("t3_order", {gr[0][7:0], gr[1][7:0], gr[2][7:0], gr[3][7:0]}, 64'h00010001);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (4) step();

        // Response back-pressure
        bus.rsp0_ready = 1'b0;
        send(1'b0, 32'h7fffffff, 32'h1, 3'b000);
        bus.req1_valid = 1'b1; bus.req1_a = 32'h3; bus.req1_b = 32'h2; bus.req1_op = 3'b010;
        wait_rsp(1'b0);
        held_res = bus.rsp_result;
        check("t4_result", 64'(held_res), 64'h80000000);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", 64'(bus.rsp0_valid), 64'd1);
            check("t4_hold_result", 64'(bus.rsp_result), 64'(held_res));
            check("t4_hold_flags", 64'(bus.rsp_flags), 64'h9);
            check("t4_no_ready1", 64'(bus.req1_ready), 64'd0);
            @(negedge clk);
        end
        step();
        bus.rsp0_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.req1_ready) break;
        end
        check("t4_port1_granted", 64'(bus.req1_ready), 64'd1);
        step();
        bus.req1_valid = 1'b0;
        wait_rsp(1'b1);
        check("t4_port1_result", 64'(bus.rsp_result), 64'h2);
        step();

        // Reset in EXEC
        send(1'b0, 32'h7, 32'h8, 3'b000);
        rst = 1'b1;
        @(negedge clk);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("t5_rsp0_valid", 64'(bus.rsp0_valid), 64'd0);
        check("t5_result", 64'(bus.rsp_result), 64'd0);
        check("t5_flags", 64'(bus.rsp_flags), 64'd0);
        check("t5_alu_a", 64'(bus.alu_a), 64'd0);
        check("t5_alu_ctrl", 64'(bus.alu_ctrl), 64'd0);
        step();
        send(1'b0, 32'h9, 32'h4, 3'b001);
        wait_rsp(1'b0);
        check("t5_after_result", 64'(bus.rsp_result), 64'h5);
        step();

        // Opcode 110
        send(1'b0, 32'h3, 32'h4, 3'b110);
        @(negedge clk);
`ifdef ALU_ARB_OPCHECK_EN
        check("t6_rsp_early", 64'(bus.rsp0_valid), 64'd1);
        check("t6_err", 64'(bus.rsp_err), 64'd1);
        check("t6_result", 64'(bus.rsp_result), 64'd0);
        check("t6_ctrl_kept", 64'(bus.alu_ctrl), 64'd1);
`else
        check("t6_in_exec", 64'(bus.rsp0_valid), 64'd0);
        check("t6_ctrl_passed", 64'(bus.alu_ctrl), 64'd6);
        step();
        @(negedge clk);
        check("t6_rsp", 64'(bus.rsp0_valid), 64'd1);
        check("t6_err", 64'(bus.rsp_err), 64'd0);
`endif
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step();
            rst = ($urandom_range(0, 299) == 0);
            if (!bus.req0_valid || hs0) begin
                bus.req0_valid = ($urandom_range(0, 9) < 6);
                bus.req0_a  = $urandom;
                bus.req0_b  = ($urandom_range(0, 3) == 0) ? bus.req0_a : $urandom;
                bus.req0_op = rand_op();
            end
            if (!bus.req1_valid || hs1) begin
                bus.req1_valid = ($urandom_range(0, 9) < 6);
                bus.req1_a  = $urandom;
                bus.req1_b  = ($urandom_range(0, 3) == 0) ? bus.req1_a : $urandom;
                bus.req1_op = rand_op();
            end
            bus.rsp0_ready = ($urandom_range(0, 2) != 0);
            bus.rsp1_ready = ($urandom_range(0, 2) != 0);
        end
        rst = 1'b0;
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
